// File: rtl/ram2_arbiter_if.sv
// Request/acknowledge bundle for one ram2_arbiter client.
// The client drives the master side; the arbiter takes the slave side.
interface ram2_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ram2_arbiter.sv
// Two-client round-robin sequencer for the single-port ram2 memory.
// It serialises client requests onto the shared bidirectional RAM bus.
module ram2_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    ram2_arbiter_if.slave     client0,
    ram2_arbiter_if.slave     client1,
    output logic              busy,
    output logic              ram_ena,
    output logic              ram_wena,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t            state;
    logic              gnt;
    logic              last_gnt;
    logic              drive;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              ack0_q;
    logic              ack1_q;

    logic              winner;
    logic              winner_we;
    logic [ADDR_W-1:0] winner_addr;
    logic [DATA_W-1:0] winner_wdata;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        winner = client1.req;
        if (client0.req && client1.req) begin
            winner = ~last_gnt;
        end
        winner_we    = winner ? client1.we    : client0.we;
        winner_addr  = winner ? client1.addr  : client0.addr;
        winner_wdata = winner ? client1.wdata : client0.wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            drive    <= 1'b0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy     <= 1'b0;
            ram_ena  <= 1'b0;
            ram_wena <= 1'b0;
            ram_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack0_q <= 1'b0;
                    ack1_q <= 1'b0;
                    if (client0.req || client1.req) begin
                        gnt      <= winner;
                        last_gnt <= winner;
                        ram_addr <= winner_addr;
                        wdata_q  <= winner_wdata;
                        ram_ena  <= 1'b1;
                        ram_wena <= winner_we;
                        drive    <= winner_we;
                        busy     <= 1'b1;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    // The read word is on the bus from ram2 during this cycle.
                    if (!ram_wena) begin
                        if (gnt) rdata1_q <= ram_data;
                        else     rdata0_q <= ram_data;
                    end
                    ram_ena  <= 1'b0;
                    ram_wena <= 1'b0;
                    drive    <= 1'b0;
                    ack0_q   <= ~gnt;
                    ack1_q   <= gnt;
                    state    <= ACK;
                end
                ACK: begin
                    ack0_q <= 1'b0;
                    ack1_q <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus is driven only from a flop that reset clears asynchronously.
    assign ram_data      = drive ? wdata_q : {DATA_W{1'bz}};
    assign client0.ack   = ack0_q;
    assign client1.ack   = ack1_q;
    assign client0.rdata = rdata0_q;
    assign client1.rdata = rdata1_q;

endmodule

// File: doc/ram2_arbiter.md
# ram2_arbiter

Two-requester round-robin arbiter and sequencer for the 32x32 single-port `ram2` memory with its bidirectional data bus. It accepts independent read/write requests from two clients, serialises them onto the RAM port (`ena`, `wena`, `addr`, `data_io`), owns bus turnaround, and returns read data with a one-cycle acknowledge. It sits between the datapath clients and the `ram2` instance.

## Interface
- `ADDR_W`, 5, RAM address width (32 words)
- `DATA_W`, 32, RAM word width

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req0`, `req1`  in  1  client request; held high until matching ack
- `we0`, `we1`  in  1  1 = write, 0 = read; stable while req high
- `addr0`, `addr1`  in  ADDR_W  client word address
- `wdata0`, `wdata1`  in  DATA_W  client write data
- `ack0`, `ack1`  out  1  one-cycle completion pulse
- `rdata0`, `rdata1`  out  DATA_W  registered read data, valid from ack cycle, held until next read for that client
- `busy`  out  1  high in ACCESS and ACK states
- `ram_ena`  out  1  to `ram2` ena
- `ram_wena`  out  1  to `ram2` wena
- `ram_addr`  out  ADDR_W  to `ram2` addr
- `ram_data`  inout  DATA_W  to `ram2` data_io

One clock; reset is asynchronous and active-low.

## Operation
- RAM contract: `ram2` writes `ram_data` into `ram_addr` on the rising edge when `ram_ena`=1 and `ram_wena`=1; drives `ram_data` combinationally when `ram_ena`=1 and `ram_wena`=0; otherwise high-Z.
- FSM states: IDLE, ACCESS, ACK.
  - IDLE: if `req0|req1`, select a winner, latch its we/addr/wdata into internal registers, record the winner in `last_gnt`, go to ACCESS. Otherwise stay.
  - ACCESS: `ram_ena`=1, `ram_wena`=latched we, `ram_addr`=latched addr. For a write, the arbiter drives `ram_data`=latched wdata. For a read, `ram_data` is released and the read data is captured into the winner's `rdata` at the closing edge. Go to ACK.
  - ACK: winner's ack=1, `ram_ena`=0, go to IDLE.
- Arbitration: with a single request, that client wins. With both requesting, the client not equal to `last_gnt` wins. `last_gnt` resets to 1, so client 0 wins the first tie.
- Bus rule: the arbiter drives `ram_data` only in ACCESS with a latched write. All other states, and during reset, it is high-Z. It never drives while `ram_ena`=1 and `ram_wena`=0.
- Clients drop req in the cycle after seeing ack. A req still high in IDLE is treated as a new transaction.
- Writes leave `rdata` of both clients unchanged.
- Request inputs change only latched state in IDLE. Changes to we/addr/wdata during ACCESS/ACK are ignored.

## Timing
- Reset values: state IDLE, `ram_ena`=0, `ram_wena`=0, `ram_addr`=0, `ram_data`=Z, `ack0`=`ack1`=0, `rdata0`=`rdata1`=0, `busy`=0, `last_gnt`=1.
- `ram_*` outputs and acks are decoded from registered state and latches, so they are glitch-free relative to `clk`.
- Latency: req sampled high at edge N (in IDLE) -> ACCESS during cycle N..N+1 -> ack high during cycle N+1..N+2. The RAM write or read capture happens at edge N+1.
- Throughput: one transaction per 3 cycles. Back-to-back requests from both clients alternate strictly.
- Reset mid-operation:
  - Asserting `rst_n` in ACCESS releases the bus immediately and drops `ram_ena`. No ack is issued.
  - A write whose closing edge has not occurred is not performed.
  - If asserted in ACK, the ack is cut and the completed write stands.
- Address wrap: none. `ram_addr` is the latched value; addresses 0 and 31 are handled identically.

## Test plan
- Client 0 write: addr0=10, wdata0=32'hab10_4588 -> `ram_ena`/`ram_wena`=1 and `ram_data`=ab104588 for exactly one cycle, `ack0` the next cycle. Then client 0 read of addr 10 -> `rdata0`=32'hab10_4588 with `ack0`.
- Simultaneous req0/req1 after reset: client 0 write addr 8 = 32'h0000_0010, client 1 read addr 8 -> `ack0` first, then `ack1` 3 cycles later with `rdata1`=32'h0000_0010.
- Both clients hold req continuously for 6 transactions -> ack order 0,1,0,1,0,1. `busy` never drops for more than one IDLE cycle.
- Client 1 read of addr 6 after a write of 32'h7896_1255 -> `rdata1` matches, `rdata0` unchanged. The checker confirms `ram_data` is never driven by the arbiter while `ram_wena`=0.
- `rst_n` pulsed low mid-ACCESS of a client 0 write to addr 7 (old value 32'h0) -> no `ack0`, bus Z, `ram_ena`=0. A later read of addr 7 returns 32'h0, and the next tie is won by client 0.
